step_run_ctrl: RTL and testbench
================================

# step_run_ctrl

Count-enable generator that drives the `enable` input of the synchronous T-flip-flop counter. It turns a raw active-low pushbutton into exactly one debounced one-cycle `en` pulse per press (step mode). A level switch selects free-running mode, where a prescaler issues `en` once every `DIV` cycles. Sits directly upstream of the counter, between board I/O (KEY/SW) and the counter's enable.

## Interface
- `DB_CYCLES`, default 16: debounce qualification length in cycles; must be ≥2.
- `DIV`, default 1000: run-mode tick period in cycles; must be ≥2.
- `REPEAT_DLY`, default 500: auto-repeat first-pulse delay in cycles; ignored unless the macro is defined.
- `REPEAT_PER`, default 100: auto-repeat period in cycles; ignored unless the macro is defined.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `key_n` in 1: raw pushbutton, 0 = pressed, asynchronous.
- `run_sw` in 1: raw run-mode switch, 1 = run, asynchronous.
- `en` out 1: registered count-enable pulse, one cycle wide; feeds the counter `enable`.
- `pressed` out 1: registered debounced button level; 1 in HELD or RELEASE_DB.

## Operation
- Synchronizers: two-flop chains on `key_n` (reset to 1) and `run_sw` (reset to 0). `key_s` = inverted synchronized key (1 = pressed); `run_s` = synchronized switch.
- Debounce FSM, 2-bit state, with a shared counter `dcnt` of width $clog2(DB_CYCLES):
  - RELEASED: if `key_s`=1, go to PRESS_DB with `dcnt`=0.
  - PRESS_DB: if `key_s`=0, go to RELEASED. If `key_s`=1 and `dcnt`==DB_CYCLES-1, go to HELD and set `en`<=1. Otherwise increment `dcnt`.
  - HELD: if `key_s`=0, go to RELEASE_DB with `dcnt`=0.
  - RELEASE_DB: if `key_s`=1, return to HELD with no pulse. If `key_s`=0 and `dcnt`==DB_CYCLES-1, go to RELEASED. Otherwise increment `dcnt`.
- Prescaler `pcnt`, width $clog2(DIV):
  - While `run_s`=0, `pcnt` is held at 0.
  - While `run_s`=1, `pcnt` increments. At `pcnt`==DIV-1 it wraps to 0 and sets `en`<=1.
- `en` is the OR of the step pulse, the prescaler tick and (if configured) the repeat pulse. It is registered and defaults to 0 every cycle.
- Step and run modes work concurrently; the button is never masked in run mode.
- Simultaneous sources in one cycle produce a single one-cycle `en`, i.e. one count, not two.
- Reset values: `en`=0, `pressed`=0, state RELEASED, `dcnt`=0, `pcnt`=0, repeat counter 0.
- Reset mid-operation: all state clears immediately and asynchronously. A key still held after reset release is re-qualified and yields one new pulse.

## Timing
- Edge 0 is the first edge that samples the new input value.
- Step latency: `key_n` low and stable from edge 0 → `en`=1 in the cycle after edge DB_CYCLES+2, for exactly one cycle.
- Glitches shorter than DB_CYCLES cycles while in PRESS_DB produce no pulse.
- Release bounces shorter than DB_CYCLES cycles produce no extra pulse.
- Run mode: `run_sw` high from edge 0 → first `en` in the cycle after edge DIV+1, then one `en` every DIV cycles.
- Dropping `run_sw` stops ticks 2 cycles later with no partial tick. Re-asserting `run_sw` restarts a full DIV period.
- `pressed` rises on the same edge as the step `en` and falls on entry to RELEASED.
- Minimum spacing between step pulses is 2·DB_CYCLES+2 cycles.

## Configuration
- Macro `STEP_RUN_AUTO_REPEAT_EN`.
- Defined: a repeat counter runs while the state is HELD and is cleared in every other state.
  - First repeat `en` comes REPEAT_DLY cycles after the press pulse.
  - Further repeat pulses follow every REPEAT_PER cycles while the state stays HELD.
  - A release bounce (RELEASE_DB→HELD) restarts the REPEAT_DLY delay.
- Undefined: no repeat counter is built; holding the key yields exactly one pulse.

## Test plan
Parameters DB_CYCLES=4, DIV=8, REPEAT_DLY=20, REPEAT_PER=5.
- Reset: assert `reset`=0 mid-count → `en`=0, `pressed`=0 immediately. Release with key held → exactly one `en`, 6 cycles after release.
- Clean press: `key_n` low for 40 cycles → one `en` after edge 6, `pressed`=1 until 6 cycles after release. Total `en` count = 1 (macro undefined).
- Bounce: `key_n` toggles 0/1 for 3 cycles each, then stays low; release with 2-cycle bounces → exactly one `en`, no extra on release.
- Run mode: `run_sw`=1 for 100 cycles → first `en` after edge 9, then every 8 cycles, 12 pulses total. Drop `run_sw` → no further `en`.
- Collision: press timed so the step pulse lands on a prescaler tick → a single one-cycle `en`, downstream counter advances by 1.
- Macro defined: hold `key_n` low for 60 cycles → `en` at press, press+20, press+25, press+30, …, stopping once the key is released.

Source files
------------

// File: rtl/step_run_ctrl.sv
// step_run_ctrl: count-enable generator, debounced step pulse per press plus prescaled run-mode tick
// Ports: clk     - single clock, rising edge
//        reset   - asynchronous active-low reset
//        key_n   - raw pushbutton, 0 = pressed, asynchronous
//        run_sw  - raw run-mode switch, 1 = run, asynchronous
//        en      - registered one-cycle count enable for the downstream counter
//        pressed - registered debounced button level (1 while HELD or RELEASE_DB)
// Optional feature: define STEP_RUN_AUTO_REPEAT_EN to add hold-to-repeat pulses.
module step_run_ctrl #(
  parameter int DB_CYCLES  = 16,
  parameter int DIV        = 1000,
  parameter int REPEAT_DLY = 500,
  parameter int REPEAT_PER = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic run_sw,
  output logic en,
  output logic pressed
);
  localparam int DW = $clog2(DB_CYCLES);
  localparam int PW = $clog2(DIV);
  if (DB_CYCLES < 2 || DIV < 2 || REPEAT_DLY < REPEAT_PER || REPEAT_PER < 1)
    $error("step_run_ctrl: illegal parameter set");
  typedef enum logic [1:0] {RELEASED, PRESS_DB, HELD, RELEASE_DB} state_t;
  state_t r_state, w_state_nxt;
  logic [DW-1:0] r_dcnt, w_dcnt_nxt;
  logic [PW-1:0] r_pcnt;
  logic r_key_meta, r_key_sync, r_run_meta, r_run_sync;
  logic w_key_s, w_step, w_tick, w_rep, w_dlast;
  assign w_key_s = ~r_key_sync;
  assign w_dlast = r_dcnt == DW'(DB_CYCLES - 1);
  assign w_tick  = r_run_sync && r_pcnt == PW'(DIV - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_key_meta <= 1'b1;
      r_key_sync <= 1'b1;
      r_run_meta <= 1'b0;
      r_run_sync <= 1'b0;
    end else begin
      r_key_meta <= key_n;
      r_key_sync <= r_key_meta;
      r_run_meta <= run_sw;
      r_run_sync <= r_run_meta;
    end
  // One counter serves both debounce directions; it is zeroed on entry to either qualifying state.
  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_step      = 1'b0;
    case (r_state)
      RELEASED:
        if (w_key_s) begin
          w_state_nxt = PRESS_DB;
          w_dcnt_nxt  = '0;
        end
      PRESS_DB:
        if (!w_key_s) w_state_nxt = RELEASED;
        else if (w_dlast) begin
          w_state_nxt = HELD;
          w_step      = 1'b1;
        end else w_dcnt_nxt = r_dcnt + 1'b1;
      HELD:
        if (!w_key_s) begin
          w_state_nxt = RELEASE_DB;
          w_dcnt_nxt  = '0;
        end
      RELEASE_DB:
        if (w_key_s) w_state_nxt = HELD;
        else if (w_dlast) w_state_nxt = RELEASED;
        else w_dcnt_nxt = r_dcnt + 1'b1;
      default: w_state_nxt = RELEASED;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= RELEASED;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_pcnt <= '0;
    else r_pcnt <= (!r_run_sync || w_tick) ? '0 : r_pcnt + 1'b1;
`ifdef STEP_RUN_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DLY);
  logic [RW-1:0] r_rcnt;
  // After the first repeat the counter reloads so later pulses come every REPEAT_PER cycles.
  assign w_rep = r_state == HELD && r_rcnt == RW'(REPEAT_DLY - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_rcnt <= '0;
    else r_rcnt <= r_state != HELD ? '0 : w_rep ? RW'(REPEAT_DLY - REPEAT_PER) : r_rcnt + 1'b1;
`else
  assign w_rep = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      en      <= 1'b0;
      pressed <= 1'b0;
    end else begin
      en      <= w_step | w_tick | w_rep;
      pressed <= w_state_nxt == HELD || w_state_nxt == RELEASE_DB;
    end
endmodule

// File: tb/tb_step_run_ctrl.sv
// tb_step_run_ctrl: self-checking bench for step_run_ctrl with vector table, corner sequences and random stimulus
module tb_step_run_ctrl;
  localparam int DB = 4, DV = 8, RD = 20, RP = 5;
  logic clk = 1'b0, reset = 1'b0, key_n = 1'b1, run_sw = 1'b0;
  logic en, pressed;
  int checks = 0, failures = 0;
  bit mon = 0;
  always #5 clk = ~clk;
  step_run_ctrl #(.DB_CYCLES(DB), .DIV(DV), .REPEAT_DLY(RD), .REPEAT_PER(RP)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .run_sw(run_sw), .en(en), .pressed(pressed)
  );
  // Reference: level flips after DB+1 consecutive opposite synchronized samples;
  // run ticks whenever the count of consecutive run samples is a multiple of DV.
  logic mk1, mk2, mr1, mr2, mlvl, men, mpr;
  int mrun, mpc, mhc;
  logic mflip, mstep, mtick, mheld, mrep;
  assign mflip = (mk2 != mlvl) && (mrun == DB);
  assign mstep = mflip && !mlvl;
  assign mtick = mr2 && ((mpc + 1) % DV == 0);
  assign mheld = mlvl && (mrun == 0);
`ifdef STEP_RUN_AUTO_REPEAT_EN
  assign mrep = mheld && (mhc + 1 >= RD) && ((mhc + 1 - RD) % RP == 0);
`else
  assign mrep = 1'b0;
`endif
  always @(posedge clk or negedge reset)
    if (!reset) begin
      mk1 <= 0; mk2 <= 0; mr1 <= 0; mr2 <= 0; mlvl <= 0; men <= 0; mpr <= 0;
      mrun <= 0; mpc <= 0; mhc <= 0;
    end else begin
      mk1 <= ~key_n; mk2 <= mk1; mr1 <= run_sw; mr2 <= mr1;
      mlvl <= mflip ? ~mlvl : mlvl;
      mrun <= mflip ? 0 : (mk2 != mlvl ? mrun + 1 : 0);
      mpc <= mr2 ? mpc + 1 : 0;
      mhc <= mheld ? mhc + 1 : 0;
      men <= mstep | mtick | mrep;
      mpr <= mflip ? ~mlvl : mlvl;
    end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, a, e, $time);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    if (mon) begin
      chk("model_en", 32'(en), 32'(men));
      chk("model_pressed", 32'(pressed), 32'(mpr));
    end
  endtask
  task automatic count(input int n, output int pulses, output int first);
    pulses = 0;
    first = -1;
    for (int i = 0; i < n; i++) begin
      cyc();
      pulses += int'(en);
      if (en && first < 0) first = i;
    end
  endtask
  typedef struct {logic k; logic r; int n; int pulses; logic pr;} vec_t;
  vec_t tbl[5];
  int p, f, f2;
`ifdef STEP_RUN_AUTO_REPEAT_EN
  localparam int HOLD60 = 8, HOLD30 = 2;
`else
  localparam int HOLD60 = 1, HOLD30 = 1;
`endif
  initial begin
    tbl[0] = '{1'b1, 1'b0, 10, 0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 16, 1, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 10, 0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 100, 12, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 20, 0, 1'b0};
    repeat (3) cyc();
    chk("reset_en", 32'(en), 0);
    chk("reset_pressed", 32'(pressed), 0);
    reset = 1'b1;
    mon = 1;
    foreach (tbl[i]) begin
      key_n = tbl[i].k;
      run_sw = tbl[i].r;
      count(tbl[i].n, p, f);
      chk($sformatf("tbl%0d_pulses", i), p, tbl[i].pulses);
      chk($sformatf("tbl%0d_pressed", i), 32'(pressed), 32'(tbl[i].pr));
    end
    key_n = 1'b0;
    count(60, p, f);
    chk("press_latency", f, 6);
    chk("hold60_pulses", p, HOLD60);
    key_n = 1'b1;
    f = -1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (!pressed && f < 0) f = i;
    end
    chk("release_latency", f, 6);
    for (int r = 0; r < 3; r++) begin
      key_n = 1'b0; repeat (3) cyc();
      key_n = 1'b1; repeat (3) cyc();
    end
    chk("glitch_no_pulse_pressed", 32'(pressed), 0);
    key_n = 1'b0;
    count(16, p, f);
    for (int r = 0; r < 3; r++) begin
      key_n = 1'b1; count(2, f2, f); p += f2;
      key_n = 1'b0; count(2, f2, f); p += f2;
    end
    key_n = 1'b1;
    count(20, f2, f);
    p += f2;
    chk("bounce_pulses", p, 1);
    chk("bounce_pressed", 32'(pressed), 0);
    for (int r = 0; r < 2; r++) begin
      run_sw = 1'b1;
      count(12, p, f);
      chk("run_first_tick", f, 9);
      run_sw = 1'b0;
      count(6, p, f);
      chk("run_stop_pulses", p, 0);
    end
    run_sw = 1'b1;
    repeat (3) cyc();
    key_n = 1'b0;
    count(6, p, f);
    cyc();
    chk("collision_en", 32'(en), 1);
    count(1, f2, f);
    chk("collision_width", f2, 0);
    chk("collision_pulses", p + 1, 1);
    run_sw = 1'b0;
    count(20, p, f);
    key_n = 1'b1;
    repeat (20) cyc();
    key_n = 1'b0;
    run_sw = 1'b1;
    repeat (20) cyc();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_en", 32'(en), 0);
    chk("async_reset_pressed", 32'(pressed), 0);
    run_sw = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    count(30, p, f);
    chk("reset_requal_latency", f, 6);
    chk("reset_requal_pulses", p, HOLD30);
    for (int i = 0; i < 300; i++) begin
      key_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) run_sw = ~run_sw;
      repeat ($urandom_range(1, 12)) cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
